eth_frame_rx_parser: RTL and testbench
======================================

// Module: eth_frame_rx_parser
// PURPOSE
//   Downstream consumer of the pattern-generator/loopback byte stream (tdata/tvalid/tlast/tready).
//   Parses the 14-byte header (dst[47:0], src[47:0], payload_len[15:0]), sent MSB-first.
//   Filters frames on destination MAC and forwards the payload, with the header stripped, on a registered AXI-S byte port.
//   Emits one status word per frame for length, address, runt and oversize checks.
// PARAMETERS
//   MAX_SIZE   16'd500            max payload bytes forwarded per frame
//   LOCAL_MAC  48'h02_00_00_00_00_01  accepted unicast dst address
//   PROMISC    1'b0               1 = accept any dst
// PORTS
//   clk             in   1   single clock; all logic rising-edge
//   rst             in   1   synchronous, active-high reset
//   s_data          in   8   input byte (header then payload)
//   s_valid         in   1   input byte valid
//   s_last          in   1   last byte of frame
//   s_ready         out  1   block accepts byte this cycle
//   m_data          out  8   payload byte out
//   m_valid         out  1   payload byte valid
//   m_last          out  1   last forwarded payload byte
//   m_ready         in   1   downstream accepts
//   hdr_dst         out  48  captured dst; stable from hdr_valid until next header starts
//   hdr_src         out  48  captured src
//   hdr_len         out  16  captured payload_len
//   hdr_valid       out  1   1-cycle pulse: header complete, frame accepted
//   stat_valid      out  1   1-cycle pulse: frame finished
//   stat_byte_cnt   out  16  payload bytes received (forwarded + dropped); saturates at 16'hFFFF
//   stat_len_err    out  1   stat_byte_cnt != hdr_len
//   stat_addr_drop  out  1   frame discarded by dst filter
//   stat_runt       out  1   s_last arrived before header byte 13
//   stat_oversize   out  1   payload exceeded MAX_SIZE; truncated
// BEHAVIOUR
//   Reset: state=HDR, byte index=0, counters 0.
//     All outputs 0, except s_ready=1; hdr_* fields cleared.
//   Handshake: a transfer occurs when valid&&ready at the clk edge. m_valid, once high, holds m_data/m_last until m_ready.
//   Header bytes: index 0..5 -> dst[47:40]..dst[7:0]; 6..11 -> src; 12 -> len[15:8]; 13 -> len[7:0].
//   FSM:
//     HDR:     s_ready=1. On byte 13 accepted:
//              - accept = PROMISC | dst==LOCAL_MAC | dst==48'hFFFF_FFFF_FFFF.
//              - accept -> hdr_valid pulses the next cycle; go to PAY.
//              - else go to DROP and set addr_drop.
//              - If s_last is also set on byte 13 (zero payload): go to STAT.
//              s_last on byte <13 -> runt=1, go to STAT.
//     PAY:     s_ready = !m_valid | m_ready (single output register, no bubbles at full rate).
//              Each accepted byte is loaded into m_data and cnt increments.
//              m_last = s_last, or cnt reaching MAX_SIZE.
//              - Reaching MAX_SIZE without s_last: oversize=1, go to DROP.
//              - s_last: go to STAT.
//     DROP:    s_ready=1; bytes are counted, not forwarded. s_last -> go to STAT.
//     STAT:    s_ready=0 for exactly 1 cycle; stat_valid=1 with all stat_* fields; clear cnt/flags; go to HDR.
//   Latency: payload byte accepted at edge N appears on m_data at edge N (registered), i.e. one cycle after s_data.
//   A pending m_valid byte may still be waiting in STAT/HDR. The next frame's payload stalls until it drains; header bytes do not stall.
//   stat_len_err for runts: 1 unless captured len happens to match cnt (cnt=0).
//   Reset mid-frame: all state is discarded, the output register is cleared, and no stat is emitted. The next input byte is treated as header byte 0.
// TESTING
//   1. dst=LOCAL_MAC, len=16, 16 payload bytes, m_ready=1:
//      - hdr_valid pulses once; 16 bytes out in order; m_last on byte 16.
//      - stat_valid with cnt=16, all error flags 0.
//   2. dst=48'h0A0B0C0D0E0F, PROMISC=0, len=8:
//      - m_valid never rises; stat_addr_drop=1, cnt=8.
//   3. len field=20, 12 bytes sent:
//      - stat_len_err=1, stat_byte_cnt=12.
//   4. MAX_SIZE=500, 510-byte payload:
//      - 500 bytes forwarded, m_last on byte 500; stat_oversize=1, cnt=510.
//   5. s_last on header byte 9:
//      - stat_runt=1, no hdr_valid, no m_valid.
//   6. m_ready toggled 1-of-3 cycles during payload:
//      - no byte lost or duplicated.
//      - rst=1 for 1 cycle mid-payload -> all outputs 0 next cycle.
//      - a fresh frame then parses correctly.

Source files
------------

// File: rtl/eth_frame_rx_parser.sv
// Ethernet-style frame receiver: captures the 14-byte header, filters on destination MAC,
// forwards the payload through a single output register and reports one status word per frame.
module eth_frame_rx_parser #(
    parameter logic [15:0] MAX_SIZE  = 16'd500,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic        PROMISC   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [47:0] hdr_dst,
    output logic [47:0] hdr_src,
    output logic [15:0] hdr_len,
    output logic        hdr_valid,
    output logic        stat_valid,
    output logic [15:0] stat_byte_cnt,
    output logic        stat_len_err,
    output logic        stat_addr_drop,
    output logic        stat_runt,
    output logic        stat_oversize
);

    typedef enum logic [1:0] {HDR, PAY, DROP, STAT} state_t;

    state_t      state, state_nx;
    logic [3:0]  idx;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        runt, addr_drop, oversize;
    logic        s_xfer, load, accept, at_max, hdr_done;
    logic [2:0]  dsel, ssel;

    assign s_xfer   = s_valid && s_ready;
    assign load     = (state == PAY) && s_xfer;
    assign hdr_done = (state == HDR) && s_xfer && (idx == 4'd13);
    // dst is complete once byte 13 arrives, so the filter can look at the register directly
    assign accept   = PROMISC || (hdr_dst == LOCAL_MAC) || (&hdr_dst);
    assign cnt_inc  = (&cnt) ? cnt : cnt + 16'd1;
    assign at_max   = ({1'b0, cnt} + 17'd1) == {1'b0, MAX_SIZE};
    assign dsel     = 3'(4'd5 - idx);
    assign ssel     = 3'(4'd11 - idx);

    assign stat_valid     = (state == STAT);
    assign stat_byte_cnt  = cnt;
    assign stat_len_err   = (cnt != hdr_len);
    assign stat_addr_drop = addr_drop;
    assign stat_runt      = runt;
    assign stat_oversize  = oversize;

    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        case (state)
            HDR: begin
                s_ready = 1'b1;
                if (s_xfer) begin
                    if (s_last)              state_nx = STAT;
                    else if (idx == 4'd13)   state_nx = accept ? PAY : DROP;
                end
            end
            PAY: begin
                s_ready = !m_valid || m_ready;
                if (s_xfer) begin
                    if (s_last)      state_nx = STAT;
                    else if (at_max) state_nx = DROP;
                end
            end
            DROP: begin
                s_ready = 1'b1;
                if (s_xfer && s_last) state_nx = STAT;
            end
            default: state_nx = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR;
            idx       <= 4'd0;
            cnt       <= 16'd0;
            runt      <= 1'b0;
            addr_drop <= 1'b0;
            oversize  <= 1'b0;
            hdr_dst   <= 48'd0;
            hdr_src   <= 48'd0;
            hdr_len   <= 16'd0;
            hdr_valid <= 1'b0;
            m_data    <= 8'd0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end else begin
            state     <= state_nx;
            hdr_valid <= hdr_done && accept;

            if ((state == HDR) && s_xfer) begin
                idx <= ((idx == 4'd13) || s_last) ? 4'd0 : idx + 4'd1;
                if (idx < 4'd6)       hdr_dst[{dsel, 3'b000} +: 8] <= s_data;
                else if (idx < 4'd12) hdr_src[{ssel, 3'b000} +: 8] <= s_data;
                else if (idx == 4'd12) hdr_len[15:8] <= s_data;
                else                  hdr_len[7:0]  <= s_data;
                if (s_last && (idx != 4'd13)) runt <= 1'b1;
                if ((idx == 4'd13) && !accept) addr_drop <= 1'b1;
            end

            if (((state == PAY) || (state == DROP)) && s_xfer) cnt <= cnt_inc;
            if (load && at_max && !s_last) oversize <= 1'b1;

            if (state == STAT) begin
                cnt       <= 16'd0;
                idx       <= 4'd0;
                runt      <= 1'b0;
                addr_drop <= 1'b0;
                oversize  <= 1'b0;
            end

            // single-entry output register; refilled in the same cycle it drains
            if (load) begin
                m_data  <= s_data;
                m_valid <= 1'b1;
                m_last  <= s_last || at_max;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_rx_parser.sv
// Scoreboard bench for eth_frame_rx_parser: expected payload, header and status words are
// queued as frames are driven and compared as the DUT emits them.
module tb_eth_frame_rx_parser;

    localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
    localparam int          MAX   = 500;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last;
    logic        m_ready = 1'b1;
    logic [47:0] hdr_dst, hdr_src;
    logic [15:0] hdr_len;
    logic        hdr_valid, stat_valid;
    logic [15:0] stat_byte_cnt;
    logic        stat_len_err, stat_addr_drop, stat_runt, stat_oversize;

    eth_frame_rx_parser dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .hdr_dst(hdr_dst), .hdr_src(hdr_src), .hdr_len(hdr_len), .hdr_valid(hdr_valid),
        .stat_valid(stat_valid), .stat_byte_cnt(stat_byte_cnt), .stat_len_err(stat_len_err),
        .stat_addr_drop(stat_addr_drop), .stat_runt(stat_runt), .stat_oversize(stat_oversize)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic last; logic [7:0] data; } pay_t;
    typedef struct packed { logic [15:0] cnt; logic len_err, addr_drop, runt, oversize; } stat_t;
    typedef struct packed { logic [47:0] dst, src; logic [15:0] len; } hdr_t;

    pay_t  pay_q[$];
    stat_t stat_q[$];
    hdr_t  hdr_q[$];

    int checks = 0;
    int errors = 0;
    int rmode  = 0;
    int rphase = 0;
    int hv_cnt = 0;
    int mv_cnt = 0;
    logic [47:0] md, ms;
    logic [15:0] ml;

    // downstream ready: always on, or one cycle in three
    always @(negedge clk) begin
        rphase++;
        m_ready = (rmode == 0) ? 1'b1 : ((rphase % 3) == 0);
    end

    always @(negedge clk) begin
        pay_t  pe;
        stat_t se;
        hdr_t  he;
        #2;
        if (!rst) begin
            if (m_valid) mv_cnt++;
            if (hdr_valid) hv_cnt++;
            if (m_valid && m_ready) begin
                checks++;
                if (pay_q.size() == 0) begin
                    errors++;
                    $display("FAIL payload_unexpected got data=%h last=%b", m_data, m_last);
                end else begin
                    pe = pay_q.pop_front();
                    if ({m_last, m_data} !== pe) begin
                        errors++;
                        $display("FAIL payload got last=%b data=%h want last=%b data=%h",
                                 m_last, m_data, pe.last, pe.data);
                    end
                end
            end
            if (stat_valid) begin
                checks++;
                if (stat_q.size() == 0) begin
                    errors++;
                    $display("FAIL stat_unexpected got cnt=%0d", stat_byte_cnt);
                end else begin
                    se = stat_q.pop_front();
                    if ({stat_byte_cnt, stat_len_err, stat_addr_drop, stat_runt, stat_oversize} !== se) begin
                        errors++;
                        $display("FAIL stat got cnt=%0d le=%b ad=%b ru=%b ov=%b want cnt=%0d le=%b ad=%b ru=%b ov=%b",
                                 stat_byte_cnt, stat_len_err, stat_addr_drop, stat_runt, stat_oversize,
                                 se.cnt, se.len_err, se.addr_drop, se.runt, se.oversize);
                    end
                end
            end
            if (hdr_valid) begin
                checks++;
                if (hdr_q.size() == 0) begin
                    errors++;
                    $display("FAIL hdr_unexpected got dst=%h", hdr_dst);
                end else begin
                    he = hdr_q.pop_front();
                    if ({hdr_dst, hdr_src, hdr_len} !== he) begin
                        errors++;
                        $display("FAIL hdr got %h/%h/%h want %h/%h/%h",
                                 hdr_dst, hdr_src, hdr_len, he.dst, he.src, he.len);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic l);
        int w;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        s_last  = l;
        #1;
        w = 0;
        while (!s_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout got 0 want 1");
        end
    endtask

    // nsend < 0 sends the whole frame; a shorter nsend aborts it (no status expected)
    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] len,
                              input int npay, input int hbytes, input int nsend, input bit idle);
        logic [7:0] h[14];
        logic [7:0] b;
        int   total;
        bit   full, acc;
        stat_t st;
        pay_t  p;
        full  = (hbytes >= 14);
        total = full ? 14 + npay : hbytes;
        if (nsend < 0 || nsend > total) nsend = total;
        for (int i = 0; i < 6; i++) begin
            h[i]   = dst[8*(5-i) +: 8];
            h[6+i] = src[8*(5-i) +: 8];
        end
        h[12] = len[15:8];
        h[13] = len[7:0];
        for (int i = 0; i < 14 && i < hbytes && i < nsend; i++) begin
            if (i < 6)       md[8*(5-i) +: 8]  = h[i];
            else if (i < 12) ms[8*(11-i) +: 8] = h[i];
            else if (i == 12) ml[15:8] = h[i];
            else             ml[7:0]  = h[i];
        end
        acc = full && ((dst == LOCAL) || (dst == 48'hFFFF_FFFF_FFFF));
        if (acc && nsend >= 14) hdr_q.push_back({md, ms, ml});
        if (nsend == total) begin
            st.cnt       = full ? 16'(npay) : 16'd0;
            st.len_err   = (st.cnt != ml);
            st.addr_drop = full && !acc;
            st.runt      = !full;
            st.oversize  = acc && (npay > MAX);
            stat_q.push_back(st);
        end
        for (int i = 0; i < nsend; i++) begin
            if (i < 14) b = h[i];
            else begin
                b = 8'($urandom_range(0, 255));
                if (acc && (i - 14) < MAX) begin
                    p.data = b;
                    p.last = (i == total - 1) || ((i - 14) == MAX - 1);
                    pay_q.push_back(p);
                end
            end
            send_byte(b, i == total - 1);
        end
        if (idle) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while ((pay_q.size() != 0 || stat_q.size() != 0 || hdr_q.size() != 0) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pay_q.size() != 0 || stat_q.size() != 0 || hdr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending pay=%0d stat=%0d hdr=%0d want 0", name,
                     pay_q.size(), stat_q.size(), hdr_q.size());
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({m_valid, m_last, m_data, hdr_valid, stat_valid, stat_byte_cnt, stat_len_err,
             stat_addr_drop, stat_runt, stat_oversize} !== '0 ||
            {hdr_dst, hdr_src, hdr_len} !== '0) begin
            errors++;
            $display("FAIL %s_outputs got mv=%b ml=%b md=%h sv=%b cnt=%0d dst=%h len=%h want all 0",
                     name, m_valid, m_last, m_data, stat_valid, stat_byte_cnt, hdr_dst, hdr_len);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_s_ready got %b want 1", name, s_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'd0;
        md = '0; ms = '0; ml = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int hv0;
        hv0 = hv_cnt;
        send_frame(LOCAL, 48'hA1A2A3A4A5A6, 16'd16, 16, 14, -1, 1);
        wait_drain("basic");
        checks++;
        if (hv_cnt - hv0 !== 1) begin
            errors++;
            $display("FAIL basic_hdr_valid got %0d pulses want 1", hv_cnt - hv0);
        end
    endtask

    task automatic test_addr_drop;
        int mv0, hv0;
        mv0 = mv_cnt; hv0 = hv_cnt;
        send_frame(48'h0A0B0C0D0E0F, 48'h111111111111, 16'd8, 8, 14, -1, 1);
        wait_drain("addr_drop");
        checks++;
        if (mv_cnt !== mv0 || hv_cnt !== hv0) begin
            errors++;
            $display("FAIL addr_drop_quiet got m_valid cycles=%0d hdr pulses=%0d want 0/0",
                     mv_cnt - mv0, hv_cnt - hv0);
        end
    endtask

    task automatic test_len_err;
        send_frame(LOCAL, 48'h222222222222, 16'd20, 12, 14, -1, 1);
        wait_drain("len_err");
    endtask

    task automatic test_oversize;
        send_frame(LOCAL, 48'h333333333333, 16'd510, 510, 14, -1, 1);
        wait_drain("oversize");
    endtask

    task automatic test_runt;
        int mv0, hv0;
        mv0 = mv_cnt; hv0 = hv_cnt;
        send_frame(LOCAL, 48'h444444444444, 16'd4, 4, 10, -1, 1);
        wait_drain("runt");
        checks++;
        if (mv_cnt !== mv0 || hv_cnt !== hv0) begin
            errors++;
            $display("FAIL runt_quiet got m_valid cycles=%0d hdr pulses=%0d want 0/0",
                     mv_cnt - mv0, hv_cnt - hv0);
        end
    endtask

    task automatic test_boundary;
        // exactly MAX bytes with s_last: truncation flag must stay clear
        send_frame(48'hFFFF_FFFF_FFFF, 48'h555555555555, 16'd500, MAX, 14, -1, 1);
        // zero-length payloads, accepted and filtered
        send_frame(LOCAL, 48'h666666666666, 16'd0, 0, 14, -1, 1);
        send_frame(48'h020000000002, 48'h777777777777, 16'd0, 0, 14, -1, 1);
        wait_drain("boundary");
    endtask

    task automatic test_back_to_back;
        rmode = 1;
        send_frame(LOCAL, 48'h888888888888, 16'd9, 9, 14, -1, 0);
        send_frame(48'hFFFF_FFFF_FFFF, 48'h999999999999, 16'd5, 5, 14, -1, 0);
        send_frame(48'h0A0B0C0D0E0F, 48'hAAAAAAAAAAAA, 16'd3, 3, 14, -1, 0);
        send_frame(LOCAL, 48'hBBBBBBBBBBBB, 16'd7, 7, 14, -1, 1);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid;
        rmode = 1;
        send_frame(LOCAL, 48'hCCCCCCCCCCCC, 16'd30, 30, 14, 22, 0);
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        #1;
        check_idle_outputs("reset_mid");
        pay_q.delete();
        stat_q.delete();
        hdr_q.delete();
        md = '0; ms = '0; ml = '0;
        rst = 1'b0;
        rmode = 0;
        send_frame(LOCAL, 48'hDDDDDDDDDDDD, 16'd6, 6, 14, -1, 1);
        wait_drain("after_reset");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_addr_drop;
        test_len_err;
        test_oversize;
        test_runt;
        test_boundary;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
